// File: rtl/mfp_irq_ctrl_if.sv
// CPU bus and IPL/IACK signals of the MFP interrupt controller.
interface mfp_irq_ctrl_if;
   logic [7:0] din;
   logic       sel;
   logic [4:0] addr;
   logic       ds;
   logic       rw;
   logic [7:0] dout;
   logic       dtack;
   logic       irq;
   logic       iack;

   modport master (output din, sel, addr, ds, rw, iack, input dout, dtack, irq);
   modport slave  (input din, sel, addr, ds, rw, iack, output dout, dtack, irq);
endinterface

// File: rtl/mfp_irq_ctrl.sv
// MFP-style interrupt controller for 16/24/32 sources (IER/IPR/ISR/IMR/AER/LVL/VR).
// Define MFP_IRQ_INPUT_SYNC_EN to pass src through a 2-stage clk_en synchroniser.
module mfp_irq_ctrl #(
   parameter int CHANNELS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clk_en,
   input  logic [CHANNELS-1:0] src,
   mfp_irq_ctrl_if.slave       bus
);
   localparam int IDX_W  = (CHANNELS == 16) ? 4 : 5;
   localparam int NBYTES = CHANNELS / 8;

   localparam logic [2:0] REG_IER = 3'd0, REG_IPR = 3'd1, REG_ISR = 3'd2, REG_IMR = 3'd3;
   localparam logic [2:0] REG_AER = 3'd4, REG_LVL = 3'd5, REG_VR  = 3'd6, REG_INP = 3'd7;

   logic [CHANNELS-1:0] ier, ipr, isr, imr, aer, lvl;
   logic [CHANNELS-1:0] ier_n, ipr_n, isr_n, imr_n, aer_n, lvl_n;
   logic [7:0]          vr, vec, vec_n;
   logic                sel_p1, iack_p1, sel_arm;
   logic [CHANNELS-1:0] c_p1;
   logic [CHANNELS-1:0] src_q, c;

`ifdef MFP_IRQ_INPUT_SYNC_EN
   logic [CHANNELS-1:0] src_p1, src_p2;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_p1 <= '0;
         src_p2 <= '0;
      end else if (clk_en) begin
         src_p1 <= src;
         src_p2 <= src_p1;
      end
   end
   assign src_q = src_p2;
`else
   assign src_q = src;
`endif

   assign c = src_q ^ ~aer;

   function automatic logic [IDX_W-1:0] msb_idx(input logic [CHANNELS-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (v[i]) r = i[IDX_W-1:0];
      return r;
   endfunction

   function automatic logic [CHANNELS-1:0] merge(input logic [CHANNELS-1:0] old,
                                                 input logic [CHANNELS-1:0] mask,
                                                 input logic [CHANNELS-1:0] data);
      return (old & ~mask) | (data & mask);
   endfunction

   logic [2:0]          reg_sel;
   logic [1:0]          byte_sel;
   logic                wr, iack_sel;
   logic [CHANNELS-1:0] bmask, wrep, wclr, pend, ack_hot, src_set, isr_clr;
   logic [IDX_W-1:0]    p_idx, s_idx;

   assign reg_sel  = bus.addr[4:2];
   assign byte_sel = bus.addr[1:0];
   // sel_arm blocks a strobe for an access already in progress when reset released
   assign wr       = clk_en & sel_arm & ~sel_p1 & bus.sel & ~bus.ds & ~bus.rw;
   assign iack_sel = clk_en & ~iack_p1 & bus.iack & ~bus.ds;

   assign pend  = ipr & imr;
   assign p_idx = msb_idx(pend);
   assign s_idx = msb_idx(isr);

   always_comb begin
      bmask = '0;
      for (int i = 0; i < CHANNELS; i++)
         bmask[i] = ((i / 8) == int'(byte_sel));
      wrep    = {NBYTES{bus.din}};
      wclr    = bmask & ~wrep;
      ack_hot = (iack_sel && (pend != '0)) ? ({{(CHANNELS-1){1'b0}}, 1'b1} << p_idx) : '0;
      src_set = {CHANNELS{clk_en}} & ier & ((lvl & c) | (~lvl & c & ~c_p1));

      ier_n = (wr && reg_sel == REG_IER) ? merge(ier, bmask, wrep) : ier;
      imr_n = (wr && reg_sel == REG_IMR) ? merge(imr, bmask, wrep) : imr;
      aer_n = (wr && reg_sel == REG_AER) ? merge(aer, bmask, wrep) : aer;
      lvl_n = (wr && reg_sel == REG_LVL) ? merge(lvl, bmask, wrep) : lvl;

      // Source sets beat CPU clears; a level source re-sets only on the clk_en after its ack
      ipr_n = ipr & ~ack_hot;
      if (wr && (reg_sel == REG_IPR || reg_sel == REG_IER))
         ipr_n = ipr_n & ~wclr;
      ipr_n = ipr_n | (src_set & ~(ack_hot & lvl));

      isr_clr = '0;
      if (wr && reg_sel == REG_ISR)
         isr_clr = wclr;
      else if (wr && reg_sel == REG_VR && byte_sel == 2'd0 && !bus.din[3])
         isr_clr = '1;
      isr_n = (isr & ~isr_clr) | (vr[3] ? ack_hot : '0);

      vec_n = (pend != '0) ? {vr[7:IDX_W], p_idx} : 8'h18;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ier     <= '0;
         ipr     <= '0;
         isr     <= '0;
         imr     <= '0;
         aer     <= '0;
         lvl     <= '0;
         vr      <= '0;
         vec     <= '0;
         sel_p1  <= 1'b0;
         iack_p1 <= 1'b0;
         sel_arm <= 1'b0;
         c_p1    <= '0;
      end else begin
         ier <= ier_n;
         ipr <= ipr_n;
         isr <= isr_n;
         imr <= imr_n;
         aer <= aer_n;
         lvl <= lvl_n;
         if (wr && reg_sel == REG_VR && byte_sel == 2'd0)
            vr <= bus.din;
         if (iack_sel)
            vec <= vec_n;
         if (clk_en) begin
            sel_p1  <= bus.sel;
            iack_p1 <= bus.iack;
            c_p1    <= c;
            if (!bus.sel)
               sel_arm <= 1'b1;
         end
      end
   end

   logic [31:0] rword;
   logic [7:0]  rbyte, dout_w;

   always_comb begin
      rword = '0;
      case (reg_sel)
         REG_IER: rword[CHANNELS-1:0] = ier;
         REG_IPR: rword[CHANNELS-1:0] = ipr;
         REG_ISR: rword[CHANNELS-1:0] = isr;
         REG_IMR: rword[CHANNELS-1:0] = imr;
         REG_AER: rword[CHANNELS-1:0] = aer;
         REG_LVL: rword[CHANNELS-1:0] = lvl;
         REG_VR:  rword[7:0]          = vr;
         REG_INP: rword[CHANNELS-1:0] = c;
         default: rword = '0;
      endcase
      rbyte = rword[{byte_sel, 3'b000} +: 8];

      // Held at 0 during reset so the live input-level read cannot leak out
      dout_w = 8'h00;
      if (!reset_n)
         dout_w = 8'h00;
      else if (bus.sel && !bus.ds && bus.rw)
         dout_w = rbyte;
      else if (bus.iack)
         dout_w = vec;
   end

   assign bus.dout  = dout_w;
   assign bus.dtack = (sel_p1 & bus.sel) | (iack_p1 & bus.iack);
   assign bus.irq   = (pend != '0) && ((isr == '0) || (p_idx > s_idx));
endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed bench for mfp_irq_ctrl with 32 sources.
module tb_mfp_irq_ctrl;
   localparam int CH = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clk_en = 1'b1;
   logic [CH-1:0] src = '0;
   int            n_checks = 0;
   int            n_errors = 0;

   mfp_irq_ctrl_if bus ();

   mfp_irq_ctrl #(.CHANNELS(CH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_en  (clk_en),
      .src     (src),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr_reg(input logic [2:0] r, input logic [1:0] b, input logic [7:0] d);
      @(negedge clk);
      bus.addr = {r, b};
      bus.din  = d;
      bus.rw   = 1'b0;
      bus.sel  = 1'b1;
      bus.ds   = 1'b0;
      @(negedge clk);
      bus.sel  = 1'b0;
      bus.ds   = 1'b1;
      bus.rw   = 1'b1;
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] r, input logic [1:0] b,
                          input logic [7:0] exp);
      logic [7:0] d;
      bus.addr = {r, b};
      bus.rw   = 1'b1;
      bus.sel  = 1'b1;
      bus.ds   = 1'b0;
      #1 d = bus.dout;
      bus.sel  = 1'b0;
      bus.ds   = 1'b1;
      chk(tag, {24'h0, d}, {24'h0, exp});
   endtask

   task automatic pulse(input int i);
      @(negedge clk);
      src[i] = 1'b1;
      @(negedge clk);
      src[i] = 1'b0;
   endtask

   task automatic do_iack(input string tag, input logic [7:0] exp_vec);
      @(negedge clk);
      bus.iack = 1'b1;
      bus.ds   = 1'b0;
      @(negedge clk);
      chk(tag, {24'h0, bus.dout}, {24'h0, exp_vec});
      chk({tag, "_dtack"}, {31'h0, bus.dtack}, 32'd1);
      bus.iack = 1'b0;
      bus.ds   = 1'b1;
   endtask

   initial begin
      bus.din  = 8'h00;
      bus.sel  = 1'b0;
      bus.addr = 5'h00;
      bus.ds   = 1'b1;
      bus.rw   = 1'b1;
      bus.iack = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_irq",   {31'h0, bus.irq},   32'd0);
      chk("rst_dtack", {31'h0, bus.dtack}, 32'd0);
      chk("rst_dout",  {24'h0, bus.dout},  32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk_reg("rst_ier0", 3'd0, 2'd0, 8'h00);
      chk_reg("rst_vr",   3'd6, 2'd0, 8'h00);
      chk_reg("inp0_aer0", 3'd7, 2'd0, 8'hFF);
      chk_reg("inp3_aer0", 3'd7, 2'd3, 8'hFF);

      // clk_en gates writes; VR has no byte 1
      clk_en = 1'b0;
      wr_reg(3'd3, 2'd0, 8'hFF);
      clk_en = 1'b1;
      chk_reg("imr_no_clken", 3'd3, 2'd0, 8'h00);
      wr_reg(3'd6, 2'd1, 8'hFF);
      chk_reg("vr_byte1", 3'd6, 2'd1, 8'h00);

      // source 20 rising edge and acknowledge
      wr_reg(3'd4, 2'd2, 8'h10);
      wr_reg(3'd4, 2'd0, 8'hFF);
      wr_reg(3'd4, 2'd1, 8'hFF);
      wr_reg(3'd0, 2'd2, 8'h10);
      wr_reg(3'd3, 2'd2, 8'h10);
      wr_reg(3'd0, 2'd0, 8'h2C);
      wr_reg(3'd3, 2'd0, 8'h2C);
      wr_reg(3'd0, 2'd1, 8'h03);
      wr_reg(3'd3, 2'd1, 8'h03);
      wr_reg(3'd6, 2'd0, 8'h48);
      chk_reg("inp0_aer1", 3'd7, 2'd0, 8'h00);
      chk("idle_irq", {31'h0, bus.irq}, 32'd0);
      pulse(20);
      chk("irq20", {31'h0, bus.irq}, 32'd1);
      chk_reg("ipr2_set", 3'd1, 2'd2, 8'h10);
      do_iack("vec20", 8'h54);
      chk("irq20_acked", {31'h0, bus.irq}, 32'd0);
      chk_reg("ipr2_clr", 3'd1, 2'd2, 8'h00);
      chk_reg("isr2_set", 3'd2, 2'd2, 8'h10);
      wr_reg(3'd2, 2'd2, 8'hEF);
      chk_reg("isr2_clr", 3'd2, 2'd2, 8'h00);

      // lower-priority request masked by in-service source 9
      pulse(9);
      do_iack("vec9", 8'h49);
      chk_reg("isr1_9", 3'd2, 2'd1, 8'h02);
      pulse(5);
      chk_reg("ipr0_5", 3'd1, 2'd0, 8'h20);
      chk("irq5_blocked", {31'h0, bus.irq}, 32'd0);
      wr_reg(3'd2, 2'd1, 8'hFD);
      chk("irq5_unblocked", {31'h0, bus.irq}, 32'd1);
      wr_reg(3'd1, 2'd0, 8'hDF);
      chk("irq5_cleared", {31'h0, bus.irq}, 32'd0);

      // level mode on source 3
      wr_reg(3'd5, 2'd0, 8'h08);
      @(negedge clk);
      src[3] = 1'b1;
      @(negedge clk);
      chk_reg("lvl_set", 3'd1, 2'd0, 8'h08);
      chk("lvl_irq", {31'h0, bus.irq}, 32'd1);
      do_iack("vec3", 8'h43);
      chk_reg("lvl_ack_clr", 3'd1, 2'd0, 8'h00);
      @(negedge clk);
      chk_reg("lvl_reset", 3'd1, 2'd0, 8'h08);
      chk("lvl_same_prio", {31'h0, bus.irq}, 32'd0);
      src[3] = 1'b0;
      wr_reg(3'd1, 2'd0, 8'hF7);
      chk_reg("lvl_cpu_clr", 3'd1, 2'd0, 8'h00);
      chk("lvl_irq_off", {31'h0, bus.irq}, 32'd0);
      wr_reg(3'd2, 2'd0, 8'hF7);
      wr_reg(3'd5, 2'd0, 8'h00);

      // spurious acknowledge
      do_iack("spurious", 8'h18);
      chk_reg("spur_isr0", 3'd2, 2'd0, 8'h00);
      chk_reg("spur_isr1", 3'd2, 2'd1, 8'h00);

      // nested service of 9 then 8, then auto-EOI
      @(negedge clk);
      src[8] = 1'b1;
      src[9] = 1'b1;
      @(negedge clk);
      src[8] = 1'b0;
      src[9] = 1'b0;
      chk_reg("ipr1_89", 3'd1, 2'd1, 8'h03);
      do_iack("vec9b", 8'h49);
      chk("irq8_blocked", {31'h0, bus.irq}, 32'd0);
      do_iack("vec8", 8'h48);
      chk_reg("isr1_0300", 3'd2, 2'd1, 8'h03);
      wr_reg(3'd6, 2'd0, 8'h40);
      chk_reg("aeoi_isr_clr", 3'd2, 2'd1, 8'h00);
      chk_reg("vr_40", 3'd6, 2'd0, 8'h40);
      pulse(8);
      chk("irq8_aeoi", {31'h0, bus.irq}, 32'd1);
      do_iack("vec8_aeoi", 8'h48);
      chk_reg("aeoi_isr_stays", 3'd2, 2'd1, 8'h00);
      chk_reg("aeoi_ipr_clr", 3'd1, 2'd1, 8'h00);

      // edge on source 2 coincides with a CPU clear of IPR[2]
      @(negedge clk);
      src[2]   = 1'b1;
      bus.addr = {3'd1, 2'd0};
      bus.din  = 8'hFB;
      bus.rw   = 1'b0;
      bus.sel  = 1'b1;
      bus.ds   = 1'b0;
      @(negedge clk);
      bus.sel  = 1'b0;
      bus.ds   = 1'b1;
      bus.rw   = 1'b1;
      src[2]   = 1'b0;
      chk_reg("set_beats_clr", 3'd1, 2'd0, 8'h04);

      // asynchronous reset in the middle of a read cycle
      @(negedge clk);
      bus.addr = {3'd1, 2'd0};
      bus.rw   = 1'b1;
      bus.sel  = 1'b1;
      bus.ds   = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_rst_dtack", {31'h0, bus.dtack}, 32'd1);
      chk("pre_rst_dout",  {24'h0, bus.dout},  32'h04);
      chk("pre_rst_irq",   {31'h0, bus.irq},   32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_irq",   {31'h0, bus.irq},   32'd0);
      chk("mid_rst_dtack", {31'h0, bus.dtack}, 32'd0);
      chk("mid_rst_dout",  {24'h0, bus.dout},  32'd0);

      // release reset while a write access is already under way
      bus.addr = {3'd0, 2'd0};
      bus.din  = 8'hFF;
      bus.rw   = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      bus.sel = 1'b0;
      bus.ds  = 1'b1;
      bus.rw  = 1'b1;
      chk_reg("no_stale_strobe", 3'd0, 2'd0, 8'h00);
      wr_reg(3'd0, 2'd0, 8'h5A);
      chk_reg("post_rst_write", 3'd0, 2'd0, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mfp_irq_ctrl.md
# mfp_irq_ctrl

Parametrised interrupt controller for the MFP family. It takes the MFP's 16-source IER/IPR/ISR/IMR/VR scheme and generalises it to 16, 24 or 32 sources, with per-source active-edge and edge/level selection. It replaces the hard-wired interrupt logic inside the MFP top level and sits between the peripheral interrupt sources and the 68000 IPL/IACK bus cycle.

## Interface
- CHANNELS, 16, number of interrupt sources; legal values 16, 24, 32.
- IDX_W, derived (4 when CHANNELS=16, else 5), width of the source index.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  bus/source sampling enable; all register state advances only when high.
- din  in  8  CPU write data.
- sel  in  1  register chip select.
- addr  in  5  register address {reg[2:0], byte[1:0]}.
- ds  in  1  data strobe, active low.
- rw  in  1  1=read, 0=write.
- dout  out  8  read data / interrupt vector.
- dtack  out  1  bus acknowledge.
- src  in  CHANNELS  raw interrupt sources.
- irq  out  1  interrupt request to CPU.
- iack  in  1  interrupt-acknowledge cycle.

## Operation
- Register map. reg selects the register; byte b covers sources 8b..8b+7. Bytes with b ≥ CHANNELS/8 read 0 and ignore writes.
  - reg 0: IER.
  - reg 1: IPR.
  - reg 2: ISR.
  - reg 3: IMR.
  - reg 4: AER (1 = rising/high active).
  - reg 5: LVL (1 = level mode).
  - reg 6: VR (byte 0 only).
  - reg 7: corrected input levels, read-only.
- Write strobe: clk_en & ~selD & sel & ~ds & ~rw, where selD is sel registered on clk_en. This gives one strobe per access.
- dtack = (selD & sel) | (iackD & iack).
- Corrected input: c = src ^ ~AER.
- Edge mode: an IPR bit sets on a 0→1 transition of c between consecutive clk_en samples, only if the matching IER bit is 1.
- Level mode: an IPR bit sets on every clk_en where c=1 and IER=1.
- Writing IER: zero bits also clear the matching IPR bits.
- Writing IPR or ISR: zero bits clear, one bits are ignored.
- Writing VR with VR[3]=0 (auto-EOI mode) clears all of ISR.
- Priority: a higher index means higher priority.
  - P = index of the highest set bit of IPR & IMR.
  - S = index of the highest set bit of ISR.
- irq = ((IPR & IMR) != 0) && (ISR == 0 || P > S). irq is combinational from registers.
- IACK sequence. iack_sel = clk_en & ~iackD & iack & ~ds. On iack_sel:
  - If IPR & IMR != 0: latch vector {VR[7:IDX_W], P}, clear IPR[P], and set ISR[P] if VR[3]=1.
  - If IPR & IMR == 0: latch the spurious vector 8'h18.
- dout:
  - Register value when sel & ~ds & rw.
  - Else the latched vector when iack.
  - Else 0.
- Simultaneous events:
  - A source set and a CPU clear of the same IPR bit in one cycle: set wins.
  - An iack ISR-set and a CPU ISR clear of the same bit in one cycle: set wins.
  - In level mode, an iack clear is followed by a re-set on the next clk_en if c is still 1.
- Reset (asynchronous, reset_n=0):
  - IER, IPR, ISR, IMR, AER, LVL, VR, the vector latch, and all edge/sync history are set to 0.
  - Outputs: irq=0, dtack=0, dout=0.
  - Deassertion mid-bus-cycle: the first strobe occurs only after sel is seen low then high again.

## Timing
- Edge detected at clk_en cycle n: the IPR bit is set and irq is visible at the clock edge ending cycle n, i.e. 1 clk after the detecting sample.
- Register writes take effect on the clock edge of the strobe cycle. Reads are combinational, zero latency.
- The vector is latched on the iack_sel edge and stays stable until the next iack_sel or reset.
- With MFP_IRQ_INPUT_SYNC_EN, add 2 clk_en samples to source-to-IPR latency.

## Configuration
- MFP_IRQ_INPUT_SYNC_EN:
  - Defined: each src bit passes through a 2-stage synchroniser clocked on clk_en before edge/level detection. Use this for asynchronous sources.
  - Undefined: src is sampled directly and must be synchronous to clk. There is no added latency.

## Test plan
- CHANNELS=32, AER[20]=1, IER[20]=IMR[20]=1, VR=8'h48. Pulse src[20]: irq=1. iack with ds low: dout=8'h54, IPR[20]=0, ISR[20]=1, irq=0.
- ISR[9]=1, then src[5] edge: IPR[5]=1 and irq stays 0. Write 0xFD to ISR byte 1 (clears ISR[9]): irq=1 next cycle.
- LVL[3]=1 with src[3] held high, then iack: IPR[3] re-sets on the next clk_en. Drop src[3], then write IPR byte 0 = 0xF7: IPR[3]=0, irq=0.
- iack with IPR & IMR = 0: dout=8'h18, ISR unchanged.
- With ISR=16'h0300, write VR=8'h40 (S=0): ISR=0. Set IPR[8] and iack: ISR stays 0.
- An edge on src[2] in the same cycle as an IPR clear write of bit 2: IPR[2]=1. Assert reset_n=0 mid-cycle: irq, dtack and dout are 0 immediately.
